// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and its datapath muxes.
// Build option: MC_CTRL_ILLEGAL_TRAP_EN (halt on unrecognised opcode/func).
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_LBU    = 6'b100100;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_JALR = 6'b001001;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  localparam logic [4:0] RT_BGEZ = 5'b00001;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BGEZ = 3'b011;
  localparam logic [2:0] BR_BGTZ = 3'b100;
  localparam logic [2:0] BR_BLEZ = 3'b101;
  localparam logic [2:0] BR_BLTZ = 3'b110;

  localparam logic [2:0] MW_LW  = 3'b000;
  localparam logic [2:0] MW_SW  = 3'b001;
  localparam logic [2:0] MW_LB  = 3'b010;
  localparam logic [2:0] MW_LBU = 3'b011;
  localparam logic [2:0] MW_SB  = 3'b101;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_LUI = 2'b10;
  localparam logic [1:0] M2R_PC4 = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_31 = 2'b10;

  localparam logic [1:0] SB_RT  = 2'b00;
  localparam logic [1:0] SB_4   = 2'b01;
  localparam logic [1:0] SB_IMM = 2'b10;
  localparam logic [1:0] SB_IM2 = 2'b11;

  localparam logic [1:0] JP_NONE = 2'b00;
  localparam logic [1:0] JP_TGT  = 2'b01;
  localparam logic [1:0] JP_REG  = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_RTYPE, C_JR, C_JALR, C_J, C_JAL,
    C_BRANCH, C_IMM, C_LUI, C_LOAD, C_STORE
  } iclass_t;

  function automatic iclass_t classify(input logic [5:0] op, input logic [5:0] func);
    iclass_t c;
    c = C_ILL;
    case (op)
      OP_RTYPE: begin
        case (func)
          F_JR:   c = C_JR;
          F_JALR: c = C_JALR;
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU: c = C_RTYPE;
          default: c = C_ILL;
        endcase
      end
      OP_J:   c = C_J;
      OP_JAL: c = C_JAL;
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: c = C_BRANCH;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI: c = C_IMM;
      OP_LUI: c = C_LUI;
      OP_LB, OP_LW, OP_LBU: c = C_LOAD;
      OP_SB, OP_SW: c = C_STORE;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  function automatic logic sext_imm(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) || (op == OP_SLTIU);
  endfunction

  function automatic logic [2:0] branch_code(input logic [5:0] op, input logic [4:0] branop);
    logic [2:0] b;
    case (op)
      OP_BEQ:    b = BR_BEQ;
      OP_BNE:    b = BR_BNE;
      OP_BGTZ:   b = BR_BGTZ;
      OP_BLEZ:   b = BR_BLEZ;
      OP_REGIMM: b = (branop == RT_BGEZ) ? BR_BGEZ : BR_BLTZ;
      default:   b = BR_NONE;
    endcase
    return b;
  endfunction

  function automatic logic [2:0] mem_code(input logic [5:0] op);
    logic [2:0] m;
    case (op)
      OP_SW:   m = MW_SW;
      OP_LB:   m = MW_LB;
      OP_LBU:  m = MW_LBU;
      OP_SB:   m = MW_SB;
      default: m = MW_LW;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath/memory-port bundle: decoded fields in, control encodings out.
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] func;
  logic [4:0] branop;
  logic       mem_ready;
  logic       mem_req;
  logic       IRWr;
  logic       PCWr;
  logic       RegWr;
  logic       ExtOp;
  logic       ALUSrcA;
  logic [1:0] RegDst;
  logic [1:0] ALUSrcB;
  logic [2:0] Branch;
  logic [1:0] Jump;
  logic [2:0] MemWr;
  logic [1:0] MemtoReg;

  modport master (
    input  op, func, branop, mem_ready,
    output mem_req, IRWr, PCWr, RegWr, ExtOp, ALUSrcA, RegDst, ALUSrcB,
           Branch, Jump, MemWr, MemtoReg
  );

  modport slave (
    output op, func, branop, mem_ready,
    input  mem_req, IRWr, PCWr, RegWr, ExtOp, ALUSrcA, RegDst, ALUSrcB,
           Branch, Jump, MemWr, MemtoReg
  );
endinterface

// File: rtl/mc_ctrl_wdog.sv
// Memory-wait watchdog: counts stalled request cycles, flags the cycle the limit is hit.
module mc_ctrl_wdog #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic start,
  input  logic waiting,
  input  logic ready,
  output logic expire
);
  logic [7:0] cnt;

  // Clearing on every non-stalled cycle means each new access begins at zero.
  always_ff @(posedge clk) begin
    if (start || !waiting || ready) cnt <= '0;
    else                            cnt <= cnt + 8'd1;
  end

  assign expire = waiting && !ready && (cnt == 8'(WAIT_MAX));
endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) with retire counter.
// Build option: MC_CTRL_ILLEGAL_TRAP_EN halts on unrecognised opcode/func; default runs them as NOP.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  mc_ctrl_if.master        bus,
  output logic             halt,
  output logic [CNT_W-1:0] instr_cnt
);
  state_t     state, nxt;
  logic [5:0] op_q, func_q;
  logic [4:0] branop_q;
  iclass_t    dec_cls, cls_q;
  logic       req, retire, expire;

  assign dec_cls = classify(bus.op, bus.func);
  assign cls_q   = classify(op_q, func_q);

  // Strobes are suppressed while rst is held so no access starts before release.
  assign req         = ((state == S_FETCH) || (state == S_MEM)) && !rst;
  assign bus.mem_req = req;
  assign halt        = (state == S_HALT);

  mc_ctrl_wdog #(.WAIT_MAX(WAIT_MAX)) u_wdog (
    .clk    (clk),
    .start  (rst),
    .waiting(req),
    .ready  (bus.mem_ready),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      instr_cnt <= '0;
      op_q      <= '0;
      func_q    <= '0;
      branop_q  <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) begin
        op_q     <= bus.op;
        func_q   <= bus.func;
        branop_q <= bus.branop;
      end
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    nxt          = state;
    retire       = 1'b0;
    bus.IRWr     = 1'b0;
    bus.PCWr     = 1'b0;
    bus.RegWr    = 1'b0;
    bus.ExtOp    = 1'b0;
    bus.ALUSrcA  = 1'b0;
    bus.RegDst   = RD_RT;
    bus.ALUSrcB  = SB_RT;
    bus.Branch   = BR_NONE;
    bus.Jump     = JP_NONE;
    bus.MemWr    = MW_LW;
    bus.MemtoReg = M2R_ALU;
    case (state)
      S_FETCH: begin
        bus.ALUSrcB = SB_4;
        if (bus.mem_ready) begin
          bus.IRWr = !rst;
          bus.PCWr = !rst;
          nxt      = S_DECODE;
        end else if (expire) begin
          nxt = S_HALT;
        end
      end
      S_DECODE: begin
        case (dec_cls)
          C_J, C_JAL: begin
            bus.Jump = JP_TGT;
            bus.PCWr = 1'b1;
            if (dec_cls == C_JAL) begin
              bus.RegWr    = 1'b1;
              bus.RegDst   = RD_31;
              bus.MemtoReg = M2R_PC4;
            end
            retire = 1'b1;
            nxt    = S_FETCH;
          end
          C_ILL: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            nxt = S_HALT;
`else
            retire = 1'b1;
            nxt    = S_FETCH;
`endif
          end
          default: nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        nxt = S_WB;
        case (cls_q)
          C_RTYPE: bus.ALUSrcA = 1'b1;
          C_JR, C_JALR: begin
            bus.Jump = JP_REG;
            bus.PCWr = 1'b1;
            if (cls_q == C_JALR) begin
              bus.RegWr    = 1'b1;
              bus.RegDst   = RD_31;
              bus.MemtoReg = M2R_PC4;
            end
            retire = 1'b1;
            nxt    = S_FETCH;
          end
          C_IMM: begin
            bus.ExtOp   = sext_imm(op_q);
            bus.ALUSrcB = SB_IMM;
          end
          C_LOAD, C_STORE: begin
            bus.ExtOp   = 1'b1;
            bus.ALUSrcB = SB_IMM;
            nxt         = S_MEM;
          end
          C_BRANCH: begin
            bus.ALUSrcA = 1'b1;
            bus.Branch  = branch_code(op_q, branop_q);
            retire      = 1'b1;
            nxt         = S_FETCH;
          end
          default: nxt = S_WB;
        endcase
      end
      S_MEM: begin
        bus.MemWr = mem_code(op_q);
        if (bus.mem_ready) begin
          if (cls_q == C_STORE) begin
            retire = 1'b1;
            nxt    = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end else if (expire) begin
          nxt = S_HALT;
        end
      end
      S_WB: begin
        bus.RegWr = 1'b1;
        retire    = 1'b1;
        nxt       = S_FETCH;
        case (cls_q)
          C_RTYPE: bus.RegDst   = RD_RD;
          C_LUI:   bus.MemtoReg = M2R_LUI;
          C_LOAD:  bus.MemtoReg = M2R_MEM;
          default: bus.MemtoReg = M2R_ALU;
        endcase
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_FETCH;
    endcase
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: driver queues per-cycle expected controls, monitor checks them.
// Honours MC_CTRL_ILLEGAL_TRAP_EN for the illegal-opcode case.
module tb_mc_ctrl;
  typedef struct packed {
    logic        mem_req, irwr, pcwr, regwr, extop, alusrca;
    logic [1:0]  regdst, alusrcb;
    logic [2:0]  branch;
    logic [1:0]  jump;
    logic [2:0]  memwr;
    logic [1:0]  memtoreg;
    logic        halt;
    logic [31:0] cnt;
  } ctl_t;

  logic        clk, rst, halt;
  logic [31:0] instr_cnt;
  logic [31:0] cnt_exp;
  int unsigned n_cmp, n_bad;
  ctl_t        exp_q[$];
  string       nm_q[$];

  mc_ctrl_if bus();

  mc_ctrl #(.WAIT_MAX(4), .CNT_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .halt     (halt),
    .instr_cnt(instr_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running, required done");
    $fatal(1);
  end

  // Monitor: one expected control vector per queued cycle
  initial begin
    ctl_t got, e;
    string nm;
    n_cmp = 0;
    n_bad = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        got.mem_req  = bus.mem_req;
        got.irwr     = bus.IRWr;
        got.pcwr     = bus.PCWr;
        got.regwr    = bus.RegWr;
        got.extop    = bus.ExtOp;
        got.alusrca  = bus.ALUSrcA;
        got.regdst   = bus.RegDst;
        got.alusrcb  = bus.ALUSrcB;
        got.branch   = bus.Branch;
        got.jump     = bus.Jump;
        got.memwr    = bus.MemWr;
        got.memtoreg = bus.MemtoReg;
        got.halt     = halt;
        got.cnt      = instr_cnt;
        n_cmp++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL %s: got %h required %h", nm, got, e);
        end
      end
    end
  end

  function automatic ctl_t z();
    ctl_t e;
    e     = '0;
    e.cnt = cnt_exp;
    return e;
  endfunction

  function automatic ctl_t fe(input logic rdy);
    ctl_t e;
    e         = z();
    e.mem_req = 1'b1;
    e.alusrcb = 2'b01;
    e.irwr    = rdy;
    e.pcwr    = rdy;
    return e;
  endfunction

  task automatic ir(input logic [5:0] o, input logic [5:0] f, input logic [4:0] b);
    bus.op     = o;
    bus.func   = f;
    bus.branop = b;
  endtask

  task automatic cyc(input logic rdy, input ctl_t e, input string nm);
    bus.mem_ready = rdy;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ctl_t e;
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    cnt_exp   = 0;
    e         = z();
    e.alusrcb = 2'b01;
    cyc(1'b0, e, "reset_state");
    rst = 1'b0;
  endtask

  initial begin
    ctl_t e;
    rst = 1'b1;
    cnt_exp = 0;
    ir(6'b0, 6'b0, 5'b0);
    bus.mem_ready = 1'b0;
    do_reset();

    // add, zero wait
    ir(6'b000000, 6'b100000, 5'b0);
    cyc(1, fe(1), "add_F");
    cyc(0, z(), "add_D");
    e = z(); e.alusrca = 1; cyc(0, e, "add_E");
    e = z(); e.regwr = 1; e.regdst = 2'b01; cyc(0, e, "add_WB");
    cnt_exp++;

    // lw with 3 wait cycles in MEM
    ir(6'b100011, 6'b0, 5'b0);
    cyc(1, fe(1), "lw_F");
    cyc(0, z(), "lw_D");
    e = z(); e.extop = 1; e.alusrcb = 2'b10; cyc(0, e, "lw_E");
    e = z(); e.mem_req = 1; e.memwr = 3'b000;
    for (int i = 0; i < 3; i++) cyc(0, e, "lw_M_wait");
    cyc(1, e, "lw_M_done");
    e = z(); e.regwr = 1; e.memtoreg = 2'b01; cyc(0, e, "lw_WB");
    cnt_exp++;

    // REGIMM bgez then bltz
    ir(6'b000001, 6'b0, 5'b00001);
    cyc(1, fe(1), "bgez_F");
    cyc(0, z(), "bgez_D");
    e = z(); e.alusrca = 1; e.branch = 3'b011; cyc(0, e, "bgez_E");
    cnt_exp++;
    ir(6'b000001, 6'b0, 5'b00000);
    cyc(1, fe(1), "bltz_F");
    cyc(0, z(), "bltz_D");
    e = z(); e.alusrca = 1; e.branch = 3'b110; cyc(0, e, "bltz_E");
    cnt_exp++;

    // jal, jalr
    ir(6'b000011, 6'b0, 5'b0);
    cyc(1, fe(1), "jal_F");
    e = z(); e.jump = 2'b01; e.pcwr = 1; e.regwr = 1; e.regdst = 2'b10; e.memtoreg = 2'b11;
    cyc(0, e, "jal_D");
    cnt_exp++;
    ir(6'b000000, 6'b001001, 5'b0);
    cyc(1, fe(1), "jalr_F");
    cyc(0, z(), "jalr_D");
    e = z(); e.jump = 2'b10; e.pcwr = 1; e.regwr = 1; e.regdst = 2'b10; e.memtoreg = 2'b11;
    cyc(0, e, "jalr_E");
    cnt_exp++;

    // sw: ready arrives on the cycle the count reaches WAIT_MAX
    ir(6'b101011, 6'b0, 5'b0);
    cyc(1, fe(1), "sw_F");
    cyc(0, z(), "sw_D");
    e = z(); e.extop = 1; e.alusrcb = 2'b10; cyc(0, e, "sw_E");
    e = z(); e.mem_req = 1; e.memwr = 3'b001;
    for (int i = 0; i < 4; i++) cyc(0, e, "sw_M_wait");
    cyc(1, e, "sw_M_done");
    cnt_exp++;

    // ori (zero-extend), lui, j
    ir(6'b001101, 6'b0, 5'b0);
    cyc(1, fe(1), "ori_F");
    cyc(0, z(), "ori_D");
    e = z(); e.alusrcb = 2'b10; cyc(0, e, "ori_E");
    e = z(); e.regwr = 1; cyc(0, e, "ori_WB");
    cnt_exp++;
    ir(6'b001111, 6'b0, 5'b0);
    cyc(1, fe(1), "lui_F");
    cyc(0, z(), "lui_D");
    cyc(0, z(), "lui_E");
    e = z(); e.regwr = 1; e.memtoreg = 2'b10; cyc(0, e, "lui_WB");
    cnt_exp++;
    ir(6'b000010, 6'b0, 5'b0);
    cyc(1, fe(1), "j_F");
    e = z(); e.jump = 2'b01; e.pcwr = 1; cyc(0, e, "j_D");
    cnt_exp++;

    // illegal opcode
    ir(6'b111111, 6'b0, 5'b0);
    cyc(1, fe(1), "ill_F");
    cyc(0, z(), "ill_D");
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    e = z(); e.halt = 1;
    cyc(1, e, "ill_halt");
    cyc(1, e, "ill_halt_hold");
`else
    cnt_exp++;
    cyc(0, fe(0), "ill_nop_cnt");
`endif
    do_reset();

    // fetch timeout with WAIT_MAX=4
    ir(6'b000000, 6'b100000, 5'b0);
    for (int i = 0; i < 5; i++) cyc(0, fe(0), "to_F_wait");
    e = z(); e.halt = 1;
    for (int i = 0; i < 3; i++) cyc(1, e, "to_halt");
    do_reset();

    ir(6'b000000, 6'b100000, 5'b0);
    cyc(1, fe(1), "add2_F");
    cyc(0, z(), "add2_D");
    e = z(); e.alusrca = 1; cyc(0, e, "add2_E");
    e = z(); e.regwr = 1; e.regdst = 2'b01; cyc(0, e, "add2_WB");
    cnt_exp++;
    cyc(0, fe(0), "add2_cnt");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
